// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// fetch port (IF) and the data port (DM). One access is in flight at a time.
// DM wins arbitration unless fetch has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LATENCY    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t                state;
  owner_t                owner;
  logic [CNT_W-1:0]      cnt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  starve_hit;
  logic                  grant_dm;
  logic                  grant_if;

  // Arbitration: DM first, unless a waiting fetch has hit its starvation limit
  always_comb begin
    starve_hit = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
    grant_dm   = dm_req && !starve_hit;
    grant_if   = !grant_dm && if_req;
  end

  // Stalls follow the request level and drop in the completion cycle
  always_comb begin
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

  // Access sequencer: grant in IDLE, count latency in BUSY, pulse done in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      cnt        <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner     <= OWN_DM;
            mem_en    <= 1'b1;
            mem_wr    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= BUSY;
            if (if_req) begin
              if (starve_cnt != STARVE_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end else begin
              starve_cnt <= '0;
            end
          end else if (grant_if) begin
            owner      <= OWN_IF;
            mem_en     <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= BUSY;
            starve_cnt <= '0;
          end
        end
        BUSY: begin
          mem_en <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!mem_wr) begin
              if (owner == OWN_DM) dm_rdata <= mem_rdata;
              else                 if_rdata <= mem_rdata;
            end
            if (owner == OWN_DM) dm_done <= 1'b1;
            else                 if_done <= 1'b1;
            mem_wr <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the memory port arbiter, with a
// LATENCY=4 instance for most scenarios and a LATENCY=1 instance for
// back-to-back throughput.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  // LATENCY=4 instance signals
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;

  // LATENCY=1 instance signals
  logic        l1_if_req, l1_dm_req, l1_dm_wr;
  logic [15:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
  logic [15:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_if_done, l1_if_stall, l1_dm_done, l1_dm_stall, l1_mem_en, l1_mem_wr;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  age;
  logic [3:0]  cur_age;
  logic        grant_is_dm;
  int          waited;
  logic [15:0] l1_addrs [3];
  logic [15:0] l1_words [3];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_done(l1_if_done),
    .if_stall(l1_if_stall),
    .dm_req(l1_dm_req), .dm_wr(l1_dm_wr), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_done(l1_dm_done), .dm_stall(l1_dm_stall),
    .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word is address + 0xBEDF, driven only in the 4th cycle after mem_en
  always @(posedge clk or negedge rst) begin
    if (!rst) age <= 4'd0;
    else if (mem_en) age <= 4'd2;
    else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
  end
  assign cur_age      = mem_en ? 4'd1 : age;
  assign mem_rdata    = (cur_age == 4'd4) ? (mem_addr + 16'hBEDF) : 16'hDEAD;
  assign l1_mem_rdata = l1_mem_en ? (l1_mem_addr + 16'hBEDF) : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    l1_if_req = 1'b0; l1_if_addr = '0; l1_dm_req = 1'b0; l1_dm_wr = 1'b0;
    l1_dm_addr = '0; l1_dm_wdata = '0;
    l1_addrs[0] = 16'h0050; l1_addrs[1] = 16'h0060; l1_addrs[2] = 16'h0070;
    l1_words[0] = 16'hBF2F; l1_words[1] = 16'hBF3F; l1_words[2] = 16'hBF4F;

    // Reset state
    tick();
    tick();
    check_bit("rst_mem_en", mem_en, 1'b0);
    check_bit("rst_mem_wr", mem_wr, 1'b0);
    check_word("rst_mem_addr", mem_addr, 16'h0000);
    check_bit("rst_if_done", if_done, 1'b0);
    check_bit("rst_dm_done", dm_done, 1'b0);
    check_word("rst_if_rdata", if_rdata, 16'h0000);
    rst = 1'b1;
    tick();

    // Single IF read
    $display("[TB] single IF read");
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    check_bit("if_stall_t0", if_stall, 1'b1);
    for (int t = 1; t <= 5; t++) begin
      tick();
      check_bit("if_mem_en", mem_en, t == 1);
      check_bit("if_done", if_done, t == 5);
      check_bit("if_stall", if_stall, t != 5);
      if (t == 1) begin
        check_word("if_mem_addr", mem_addr, 16'h0010);
        check_bit("if_mem_wr", mem_wr, 1'b0);
      end
    end
    check_word("if_rdata", if_rdata, 16'hBEEF);
    if_req = 1'b0;
    tick();
    check_bit("if_done_after", if_done, 1'b0);

    // Simultaneous requests: DM first, then IF from IDLE after DONE
    $display("[TB] simultaneous requests");
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
    for (int t = 1; t <= 11; t++) begin
      tick();
      check_bit("sim_mem_en", mem_en, (t == 1) || (t == 7));
      check_bit("sim_dm_done", dm_done, t == 5);
      check_bit("sim_if_done", if_done, t == 11);
      if (t == 1) check_word("sim_first_addr", mem_addr, 16'h0100);
      if (t == 7) check_word("sim_second_addr", mem_addr, 16'h0020);
      if (t == 5) begin
        check_word("sim_dm_rdata", dm_rdata, 16'hBFDF);
        dm_req = 1'b0;
      end
    end
    check_word("sim_if_rdata", if_rdata, 16'hBEFF);
    if_req = 1'b0;
    tick();

    // DM write
    $display("[TB] DM write");
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check_bit("wr_mem_wr", mem_wr, t != 5);
      check_bit("wr_dm_done", dm_done, t == 5);
      if (t != 5) check_word("wr_mem_wdata", mem_wdata, 16'h1234);
    end
    check_word("wr_mem_addr", mem_addr, 16'h0200);
    check_word("wr_dm_rdata_kept", dm_rdata, 16'hBFDF);
    dm_req = 1'b0; dm_wr = 1'b0;
    tick();

    // Starvation guard: both held high, order DM,DM,DM,IF repeating
    $display("[TB] starvation guard");
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_addr = 16'h0300;
    for (int g = 0; g < 8; g++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!mem_en && waited < 10);
      check_bit("starve_grant_seen", mem_en, 1'b1);
      grant_is_dm = (mem_addr == 16'h0300);
      check_bit("starve_order", grant_is_dm, (g % 4) != 3);
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int t = 0; t < 6; t++) tick();

    // Reset in the middle of a DM read
    $display("[TB] reset mid-access");
    dm_req = 1'b1; dm_addr = 16'h0400;
    tick();
    tick();
    dm_req = 1'b0;
    rst = 1'b0;
    #1;
    check_bit("mid_rst_mem_en", mem_en, 1'b0);
    check_bit("mid_rst_mem_wr", mem_wr, 1'b0);
    check_word("mid_rst_mem_addr", mem_addr, 16'h0000);
    check_word("mid_rst_mem_wdata", mem_wdata, 16'h0000);
    check_word("mid_rst_if_rdata", if_rdata, 16'h0000);
    check_word("mid_rst_dm_rdata", dm_rdata, 16'h0000);
    check_bit("mid_rst_dm_done", dm_done, 1'b0);
    check_bit("mid_rst_dm_stall", dm_stall, 1'b0);
    tick();
    rst = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check_bit("post_rst_mem_en", mem_en, 1'b0);
      check_bit("post_rst_dm_done", dm_done, 1'b0);
      check_bit("post_rst_if_done", if_done, 1'b0);
    end

    // LATENCY=1 back-to-back fetches
    $display("[TB] LATENCY=1 back-to-back");
    l1_if_req = 1'b1; l1_if_addr = l1_addrs[0];
    for (int t = 1; t <= 9; t++) begin
      tick();
      check_bit("l1_mem_en", l1_mem_en, (t % 3) == 1);
      check_bit("l1_if_done", l1_if_done, (t % 3) == 2);
      if ((t % 3) == 1) check_word("l1_mem_addr", l1_mem_addr, l1_addrs[t / 3]);
      if ((t % 3) == 2) check_word("l1_if_rdata", l1_if_rdata, l1_words[t / 3]);
      if ((t % 3) == 0 && (t / 3) < 3) l1_if_addr = l1_addrs[t / 3];
    end
    l1_if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
